intc: RTL



---
 rtl/intc_pkg.sv | 22 ++
 rtl/intc_src.sv | 31 +++
 rtl/intc.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared CSR offsets, bus widths and FSM encodings for the intc interrupt controller.
package intc_pkg;

    localparam int unsigned CSR_AW = 5;
    localparam int unsigned CSR_DW = 8;

    localparam int unsigned INTC_IE       = 0;
    localparam int unsigned INTC_IP       = 1;
    localparam int unsigned INTC_EDGE_CFG = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } intc_state_e;

    function automatic logic [CSR_AW-1:0] csr_addr(input logic [CSR_AW-1:0] base,
                                                   input int unsigned off);
        return base + CSR_AW'(off);
    endfunction

endpackage

// File: rtl/intc_src.sv
// One interrupt source: input history, pending bit and edge/level capture.
module intc_src (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic ack,
    input  logic edge_sel,
    output logic pending
);

    logic prev_q;
    logic ip_q;

    // prev resets high so a line already asserted out of reset raises no edge
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
            ip_q   <= 1'b0;
        end else begin
            prev_q <= irq_in;
            if (edge_sel) begin
                ip_q <= (irq_in & ~prev_q) | (ip_q & ~ack);
            end else begin
                ip_q <= irq_in;
            end
        end
    end

    assign pending = ip_q;

endmodule

// File: rtl/intc.sv
// CSR-mapped interrupt controller: IE/IP/EDGE_CFG registers and the irq_out holdoff FSM.
// Optional EDGE_CFG register (per-source edge/level) is built when INTC_EDGE_CFG_EN is defined.
module intc
    import intc_pkg::*;
#(
    parameter logic [CSR_AW-1:0] BASE_ADDR      = 5'h1c,
    parameter int unsigned       NUM_SRC        = 8,
    parameter int unsigned       HOLDOFF_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CSR_AW-1:0]   csr_a,
    input  logic [CSR_DW-1:0]   csr_di,
    input  logic                csr_we,
    output logic [CSR_DW-1:0]   csr_do,
    input  logic [NUM_SRC-1:0]  irq_in,
    output logic                irq_out
);

    localparam logic [CSR_AW-1:0] ADDR_IE = csr_addr(BASE_ADDR, INTC_IE);
    localparam logic [CSR_AW-1:0] ADDR_IP = csr_addr(BASE_ADDR, INTC_IP);
    localparam int unsigned       CNT_W   = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    logic [NUM_SRC-1:0] ie_q;
    logic [NUM_SRC-1:0] ip;
    logic [NUM_SRC-1:0] ack;
    logic [NUM_SRC-1:0] edge_sel;
    logic               wr_ie;
    logic               wr_ip;
    logic               host_ack;
    logic               active;
    logic [CSR_DW-1:0]  rd_data;
    intc_state_e        state_q;
    intc_state_e        state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    assign wr_ie    = csr_we && (csr_a == ADDR_IE);
    assign wr_ip    = csr_we && (csr_a == ADDR_IP);
    assign ack      = wr_ip ? csr_di[NUM_SRC-1:0] : '0;
    assign host_ack = wr_ip && (csr_di != '0);
    assign active   = |(ip & ie_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q <= '0;
        end else if (wr_ie) begin
            ie_q <= csr_di[NUM_SRC-1:0];
        end
    end

`ifdef INTC_EDGE_CFG_EN
    localparam logic [CSR_AW-1:0] ADDR_EC = csr_addr(BASE_ADDR, INTC_EDGE_CFG);
    logic [NUM_SRC-1:0] edge_cfg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cfg_q <= '1;
        end else if (csr_we && (csr_a == ADDR_EC)) begin
            edge_cfg_q <= csr_di[NUM_SRC-1:0];
        end
    end

    assign edge_sel = edge_cfg_q;
`else
    assign edge_sel = '1;
`endif

    for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_src
        intc_src u_src (
            .clk      (clk),
            .rst      (rst),
            .irq_in   (irq_in[i]),
            .ack      (ack[i]),
            .edge_sel (edge_sel[i]),
            .pending  (ip[i])
        );
    end

    // Readback mux; unused source bits and unmapped addresses read zero
    always_comb begin
        rd_data = '0;
        case (csr_a)
            ADDR_IE: rd_data = CSR_DW'(ie_q);
            ADDR_IP: rd_data = CSR_DW'(ip);
`ifdef INTC_EDGE_CFG_EN
            ADDR_EC: rd_data = CSR_DW'(edge_cfg_q);
`endif
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csr_do <= '0;
        end else begin
            csr_do <= rd_data;
        end
    end

    // Any nonzero IP write while asserted is taken as an ack and forces a low gap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (host_ack) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                end else if (!active) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            irq_out <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_out <= (state_d == ST_ACTIVE);
        end
    end

endmodule
